// File: rtl/mul_seq_pkg.sv
// Shared types and ALU opcodes for the multi-cycle multiply sequencer.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

    localparam logic [2:0] ALU_PASS_B = 3'b000;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;

endpackage

// File: rtl/mul_seq_regs.sv
// Datapath registers of the multiply sequencer: accumulator, shifted
// multiplicand, shifted multiplier and iteration counter.
module mul_seq_regs #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic                  i_acc_we,
    input  logic [DATA_WIDTH-1:0] i_op_a,
    input  logic [DATA_WIDTH-1:0] i_op_b,
    input  logic [DATA_WIDTH-1:0] i_acc_d,
    output logic [DATA_WIDTH-1:0] o_acc,
    output logic [DATA_WIDTH-1:0] o_mcand,
    output logic [DATA_WIDTH-1:0] o_mplier,
    output logic [CNT_W-1:0]      o_count
);

    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [CNT_W-1:0]      r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
        end else if (i_load) begin
            r_acc    <= '0;
            r_mcand  <= i_op_a;
            r_mplier <= i_op_b;
            r_count  <= '0;
        end else if (i_step) begin
            if (i_acc_we) begin
                r_acc <= i_acc_d;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CNT_W'(1);
        end
    end

    assign o_acc    = r_acc;
    assign o_mcand  = r_mcand;
    assign o_mplier = r_mplier;
    assign o_count  = r_count;

endmodule

// File: rtl/mul_sequencer.sv
// Shift-and-add multiply controller that borrows the shared ALU for one add
// per cycle and returns the low DATA_WIDTH bits of op_a * op_b.
module mul_sequencer
    import mul_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 64,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_cntrl,
    input  logic [DATA_WIDTH-1:0] alu_result
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_product;

    logic [DATA_WIDTH-1:0] w_acc;
    logic [DATA_WIDTH-1:0] w_mcand;
    logic [DATA_WIDTH-1:0] w_mplier;
    logic [CNT_W-1:0]      w_count;

    logic                  w_in_iter;
    logic                  w_accept;
    logic                  w_add;
    logic                  w_exit;
    logic [DATA_WIDTH-1:0] w_final;

    assign w_in_iter = (r_state == ITER);
    assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_add     = w_in_iter && w_mplier[0];

    // Early exit looks at the multiplier as it will be after this cycle's shift.
    assign w_exit  = w_in_iter &&
                     ((w_count == CNT_W'(DATA_WIDTH - 1)) ||
                      (EARLY_EXIT && (w_mplier[DATA_WIDTH-1:1] == '0)));
    assign w_final = w_mplier[0] ? alu_result : w_acc;

    mul_seq_regs #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_regs (
        .clk      (clk),
        .rst_n    (reset),
        .i_load   (w_accept),
        .i_step   (w_in_iter),
        .i_acc_we (w_add),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .i_acc_d  (alu_result),
        .o_acc    (w_acc),
        .o_mcand  (w_mcand),
        .o_mplier (w_mplier),
        .o_count  (w_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_product <= '0;
        end else begin
            r_state <= w_next;
            if (w_exit) begin
                r_product <= w_final;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        alu_a     = '0;
        alu_b     = '0;
        alu_cntrl = ALU_PASS_B;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = ITER;
                end
            end
            ITER: begin
                alu_a     = w_acc;
                alu_b     = w_mcand;
                alu_cntrl = w_mplier[0] ? ALU_ADD : ALU_PASS_B;
                if (w_exit) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_next = start ? ITER : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign busy    = (r_state == ITER);
    assign done    = (r_state == DONE);
    assign product = r_product;

endmodule

// File: tb/tb_mul_sequencer.sv
// Randomized bench: two sequencers (early exit on/off) share stimulus and are
// compared against plain-arithmetic products and latencies.
module tb_mul_sequencer;

    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;

    logic          busy1, done1, busy0, done0;
    logic [DW-1:0] prod1, a1, b1, res1, prod0, a0, b0, res0;
    logic [2:0]    c1, c0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign res1 = (c1 == 3'b010) ? a1 + b1 : ((c1 == 3'b000) ? b1 : '0);
    assign res0 = (c0 == 3'b010) ? a0 + b0 : ((c0 == 3'b000) ? b0 : '0);

    mul_sequencer #(.DATA_WIDTH(DW), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk(clk), .reset(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy1), .done(done1), .product(prod1),
        .alu_a(a1), .alu_b(b1), .alu_cntrl(c1), .alu_result(res1)
    );

    mul_sequencer #(.DATA_WIDTH(DW), .EARLY_EXIT(1'b0)) u_dut_fix (
        .clk(clk), .reset(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy0), .done(done0), .product(prod0),
        .alu_a(a0), .alu_b(b0), .alu_cntrl(c0), .alu_result(res0)
    );

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int ee_iters(input logic [DW-1:0] b);
        for (int i = DW - 1; i >= 0; i--) begin
            if (b[i]) return i + 1;
        end
        return 1;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy1"}, 64'(busy1), 64'd0);
        check({tag, "_done1"}, 64'(done1), 64'd0);
        check({tag, "_busy0"}, 64'(busy0), 64'd0);
        check({tag, "_done0"}, 64'(done0), 64'd0);
        check({tag, "_alu_a"}, a1, 64'd0);
        check({tag, "_alu_b"}, b1, 64'd0);
        check({tag, "_cntrl"}, 64'(c1), 64'd0);
    endtask

    task automatic run(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int            exp_it;
        int            lat1;
        int            lat0;
        logic [DW-1:0] exp_p;
        logic [DW-1:0] mask;
        exp_it = ee_iters(b);
        exp_p  = a * b;
        lat1   = -1;
        lat0   = -1;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 80 && (lat1 < 0 || lat0 < 0); cyc++) begin
            @(negedge clk);
            if (cyc <= exp_it) begin
                mask = (64'd1 << (cyc - 1)) - 64'd1;
                check("iter_busy", 64'(busy1), 64'd1);
                check("iter_cntrl", 64'(c1), b[cyc-1] ? 64'd2 : 64'd0);
                check("iter_alu_a", a1, a * (b & mask));
                check("iter_alu_b", b1, a << (cyc - 1));
            end
            if (done1 && lat1 < 0) begin
                lat1 = cyc;
                check("prod_ee", prod1, exp_p);
            end
            if (done0 && lat0 < 0) begin
                lat0 = cyc;
                check("prod_fix", prod0, exp_p);
            end
        end
        check("lat_ee", 64'(lat1), 64'(exp_it + 1));
        check("lat_fix", 64'(lat0), 64'(DW + 1));
        @(negedge clk);
        check_idle_outputs("after_run");
    endtask

    task automatic back_to_back();
        int            d1[$];
        int            d0[$];
        logic [DW-1:0] p1[$];
        logic [DW-1:0] p0[$];
        @(negedge clk);
        op_a  = 64'd5;
        op_b  = 64'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        op_a = 64'd6;
        op_b = 64'd6;
        for (int cyc = 1; cyc <= 70; cyc++) begin
            @(negedge clk);
            if (done1) begin d1.push_back(cyc); p1.push_back(prod1); end
            if (done0) begin d0.push_back(cyc); p0.push_back(prod0); end
            if (cyc == 4) begin
                check("b2b_no_bubble", 64'(busy1), 64'd1);
                start = 1'b0;
            end
        end
        check("b2b_ee_pulses", 64'(d1.size()), 64'd2);
        check("b2b_fix_pulses", 64'(d0.size()), 64'd1);
        if (d1.size() == 2) begin
            check("b2b_first_cyc", 64'(d1[0]), 64'd3);
            check("b2b_first_prod", p1[0], 64'd15);
            check("b2b_second_cyc", 64'(d1[1]), 64'd7);
            check("b2b_second_prod", p1[1], 64'd36);
        end
        if (d0.size() == 1) begin
            check("b2b_fix_cyc", 64'(d0[0]), 64'd65);
            check("b2b_fix_prod", p0[0], 64'd15);
        end
    endtask

    task automatic reset_mid_run();
        int saw_done;
        saw_done = 0;
        @(negedge clk);
        op_a  = 64'd9;
        op_b  = 64'hFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_busy1", 64'(busy1), 64'd0);
        check("rst_mid_done1", 64'(done1), 64'd0);
        check("rst_mid_prod1", prod1, 64'd0);
        check("rst_mid_busy0", 64'(busy0), 64'd0);
        check("rst_mid_prod0", prod0, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 70; cyc++) begin
            @(negedge clk);
            if (done1 || done0 || busy1 || busy0) saw_done = 1;
        end
        check("rst_no_activity", 64'(saw_done), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(negedge clk);
        check("reset_prod1", prod1, 64'd0);
        check("reset_prod0", prod0, 64'd0);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run(64'd7, 64'd5);
        run(64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
        run(64'h1234_5678_9ABC_DEF0, 64'd0);
        run(64'd3, 64'h8000_0000_0000_0001);
        run(64'd0, 64'h0000_0000_00F0_0000);
        for (int unsigned n = 0; n < 16; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(0, 63);
            run(ra, rb);
        end

        back_to_back();
        reset_mid_run();
        run(64'd11, 64'd13);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
